// File: rtl/rv_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv_regfile_pkg
//  Purpose  : Shared constants, types and the write-port priority selector for
//             the RV32 integer register file and its busy-bit scoreboard.
//  Contents : XLEN_DEF / NREGS_DEF / AW_DEF  default geometry
//             reg_addr_t                      architectural register index
//             wr_sel_t, wr_sel()              lowest-index-wins port selection
//  Revision : 1.0  initial release
// ============================================================================
package rv_regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  // The priority selector works on a fixed-width match vector so it can be
  // shared by every instance; configurations may use up to WP_MAX write ports.
  localparam int WP_MAX   = 8;
  localparam int WP_IDX_W = $clog2(WP_MAX);

  typedef logic [AW_DEF-1:0] reg_addr_t;

  typedef struct packed {
    logic                hit;
    logic [WP_IDX_W-1:0] idx;
  } wr_sel_t;

  // Returns whether any port matched and the lowest matching port index.
  // Scanning from the top down lets the lowest index overwrite the result.
  function automatic wr_sel_t wr_sel(input logic [WP_MAX-1:0] match);
    wr_sel_t res;
    res = '0;
    for (int p = WP_MAX - 1; p >= 0; p--) begin
      if (match[p]) begin
        res.hit = 1'b1;
        res.idx = WP_IDX_W'(p);
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_regfile_sb_busy.sv
`default_nettype none
// ============================================================================
//  Module   : rv_sb_busy
//  Purpose  : Busy-bit scoreboard. A destination is marked pending when an
//             instruction issues and released when a clearing write retires.
//  Ports    : clk, rst       clock / synchronous active-high reset
//             wr_en_i        write enables                 [NWR]
//             wr_addr_i      write addresses               [NWR*AW]
//             wr_clr_i       write retires a busy entry    [NWR]
//             iss_valid_i    issue request
//             iss_rd_i       issuing destination           [AW]
//             iss_ready_o    destination free (no WAW hazard)
//             rd_addr_i      read addresses                [NRD*AW]
//             rd_busy_o      read register pending (RAW)   [NRD]
//  Revision : 1.0  initial release
// ============================================================================
module rv_sb_busy
  import rv_regfile_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    wr_en_i,
  input  logic [NWR*AW-1:0] wr_addr_i,
  input  logic [NWR-1:0]    wr_clr_i,
  input  logic              iss_valid_i,
  input  logic [AW-1:0]     iss_rd_i,
  output logic              iss_ready_o,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD-1:0]    rd_busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_busy_eff;

  // Per-register release request from any write port that retires a result.
  always_comb begin
    w_clr = '0;
    for (int r = 1; r < NREGS; r++) begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en_i[p] && wr_clr_i[p] && (wr_addr_i[p*AW +: AW] == AW'(r))) begin
          w_clr[r] = 1'b1;
        end
      end
    end
  end

  // With bypass, a register being released this cycle already reads as free,
  // matching the bypassed data seen on the read ports.
  assign w_busy_eff = (BYPASS != 0) ? (busy_q & ~w_clr) : busy_q;

  // busy_q[0] is held at zero, so x0 is always ready.
  assign iss_ready_o = ~w_busy_eff[iss_rd_i];

  always_comb begin
    w_set = '0;
    if (iss_valid_i && iss_ready_o && (iss_rd_i != '0)) begin
      w_set[iss_rd_i] = 1'b1;
    end
  end

  // Set takes precedence over a same-cycle clear: the newly issued producer
  // owns the register after the older one retires.
  always_comb begin
    busy_d    = w_set | (busy_q & ~w_clr);
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rd_busy_o = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_busy_o[k] = w_busy_eff[rd_addr_i[k*AW +: AW]];
    end
  end

endmodule
`default_nettype wire

// File: rtl/rv_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : rv_regfile_sb
//  Purpose  : Multi-port RV32 integer register file with prioritised write
//             ports, optional same-cycle write bypass, hardwired x0 and an
//             integrated busy-bit scoreboard for RAW/WAW hazard reporting.
//  Ports    : clk, rst       clock / synchronous active-high reset
//             rd_addr_i      packed read addresses         [NRD*AW]
//             rd_data_o      packed read data (comb.)      [NRD*XLEN]
//             rd_busy_o      read register pending         [NRD]
//             wr_en_i        write enables, port 0 wins    [NWR]
//             wr_addr_i      write addresses               [NWR*AW]
//             wr_data_i      write data                    [NWR*XLEN]
//             wr_clr_i       write clears busy bit         [NWR]
//             iss_valid_i    issue request
//             iss_rd_i       issuing destination           [AW]
//             iss_ready_o    destination free
//  Revision : 1.0  initial release
// ============================================================================
module rv_regfile_sb
  import rv_regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic [NWR-1:0]      wr_clr_i,
  input  logic                iss_valid_i,
  input  logic [AW-1:0]       iss_rd_i,
  output logic                iss_ready_o
);

  // x0 has no storage; the array starts at x1.
  logic [XLEN-1:0] mem_q [NREGS-1:1];
  logic [XLEN-1:0] mem_d [NREGS-1:1];

  // Write data padded to the selector width so the winning index is always
  // in range; unused slots are zero.
  logic [XLEN-1:0] w_wdata [WP_MAX];
  // Read view of the file with x0 pinned to zero.
  logic [XLEN-1:0] w_mem   [NREGS];

  always_comb begin
    for (int i = 0; i < WP_MAX; i++) begin
      w_wdata[i] = '0;
    end
    for (int p = 0; p < NWR; p++) begin
      w_wdata[p] = wr_data_i[p*XLEN +: XLEN];
    end
  end

  // Write arbitration: each register takes the lowest-index matching port.
  always_comb begin
    logic [WP_MAX-1:0] match_w;
    wr_sel_t           sel_w;
    match_w = '0;
    sel_w   = '0;
    for (int r = 1; r < NREGS; r++) begin
      match_w = '0;
      for (int p = 0; p < NWR; p++) begin
        match_w[p] = wr_en_i[p] && (wr_addr_i[p*AW +: AW] == AW'(r));
      end
      sel_w    = wr_sel(match_w);
      mem_d[r] = sel_w.hit ? w_wdata[sel_w.idx] : mem_q[r];
    end
  end

  for (genvar r = 1; r < NREGS; r++) begin : g_mem
    always_ff @(posedge clk) begin
      if (rst) begin
        mem_q[r] <= '0;
      end else begin
        mem_q[r] <= mem_d[r];
      end
    end
  end

  always_comb begin
    w_mem[0] = '0;
    for (int r = 1; r < NREGS; r++) begin
      w_mem[r] = mem_q[r];
    end
  end

  // Read ports with optional bypass using the same priority as the write path,
  // so a bypassed value always equals what will be stored.
  always_comb begin
    logic [AW-1:0]     addr_r;
    logic [WP_MAX-1:0] match_r;
    wr_sel_t           sel_r;
    rd_data_o = '0;
    addr_r    = '0;
    match_r   = '0;
    sel_r     = '0;
    for (int k = 0; k < NRD; k++) begin
      addr_r  = rd_addr_i[k*AW +: AW];
      match_r = '0;
      for (int p = 0; p < NWR; p++) begin
        match_r[p] = wr_en_i[p] && (wr_addr_i[p*AW +: AW] == addr_r);
      end
      sel_r = wr_sel(match_r);
      if (addr_r == '0) begin
        rd_data_o[k*XLEN +: XLEN] = '0;
      end else if ((BYPASS != 0) && sel_r.hit) begin
        rd_data_o[k*XLEN +: XLEN] = w_wdata[sel_r.idx];
      end else begin
        rd_data_o[k*XLEN +: XLEN] = w_mem[addr_r];
      end
    end
  end

  rv_sb_busy #(
    .NREGS  (NREGS),
    .NRD    (NRD),
    .NWR    (NWR),
    .BYPASS (BYPASS)
  ) u_busy (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_clr_i    (wr_clr_i),
    .iss_valid_i (iss_valid_i),
    .iss_rd_i    (iss_rd_i),
    .iss_ready_o (iss_ready_o),
    .rd_addr_i   (rd_addr_i),
    .rd_busy_o   (rd_busy_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_rv_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv_regfile_sb
//  Purpose  : Self-checking bench for rv_regfile_sb (default geometry:
//             XLEN 32, 32 registers, 2 read ports, 2 write ports, bypass on).
//  Revision : 1.0  initial release
// ============================================================================
module tb_rv_regfile_sb;
  import rv_regfile_pkg::*;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_addr_i;
  logic [63:0] rd_data_o;
  logic [1:0]  rd_busy_o;
  logic [1:0]  wr_en_i;
  logic [9:0]  wr_addr_i;
  logic [63:0] wr_data_i;
  logic [1:0]  wr_clr_i;
  logic        iss_valid_i;
  reg_addr_t   iss_rd_i;
  logic        iss_ready_o;

  rv_regfile_sb #(
    .XLEN   (32),
    .NREGS  (32),
    .NRD    (2),
    .NWR    (2),
    .BYPASS (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr_i   (rd_addr_i),
    .rd_data_o   (rd_data_o),
    .rd_busy_o   (rd_busy_o),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .wr_clr_i    (wr_clr_i),
    .iss_valid_i (iss_valid_i),
    .iss_rd_i    (iss_rd_i),
    .iss_ready_o (iss_ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [1:0]  wr_clr;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [9:0]  rd_addr;
    logic [63:0] exp_data;
    logic [1:0]  exp_busy;
    logic        exp_ready;
  } vec_t;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  busy;
    logic        ready;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  localparam int NVEC = 22;
  vec_t tbl [NVEC];

  // Port 1 fields sit in the upper half of each packed pair.
  function automatic vec_t mk(
    input logic rs, input logic [1:0] wen,
    input logic [4:0] wa1, input logic [4:0] wa0,
    input logic [31:0] wd1, input logic [31:0] wd0,
    input logic [1:0] wclr, input logic iv, input logic [4:0] ird,
    input logic [4:0] ra1, input logic [4:0] ra0,
    input logic [31:0] ed1, input logic [31:0] ed0,
    input logic [1:0] eb, input logic er);
    vec_t v;
    v.rst       = rs;
    v.wr_en     = wen;
    v.wr_addr   = {wa1, wa0};
    v.wr_data   = {wd1, wd0};
    v.wr_clr    = wclr;
    v.iss_valid = iv;
    v.iss_rd    = ird;
    v.rd_addr   = {ra1, ra0};
    v.exp_data  = {ed1, ed0};
    v.exp_busy  = eb;
    v.exp_ready = er;
    return v;
  endfunction

  function automatic logic [31:0] pat(input int r);
    return 32'hC0DE_0000 | 32'(r);
  endfunction

  // Drive one cycle of stimulus at the falling edge, queue its expectation,
  // then sample the combinational outputs before the next rising edge.
  task automatic step(input vec_t v, input int id);
    exp_t e;
    @(negedge clk);
    rst         = v.rst;
    wr_en_i     = v.wr_en;
    wr_addr_i   = v.wr_addr;
    wr_data_i   = v.wr_data;
    wr_clr_i    = v.wr_clr;
    iss_valid_i = v.iss_valid;
    iss_rd_i    = v.iss_rd;
    rd_addr_i   = v.rd_addr;
    sb_q.push_back({v.exp_data, v.exp_busy, v.exp_ready});
    #2;
    e = sb_q.pop_front();
    checks++;
    if (rd_data_o !== e.data) begin
      errors++;
      $display("FAIL rd_data step %0d: got %h want %h", id, rd_data_o, e.data);
    end
    checks++;
    if (rd_busy_o !== e.busy) begin
      errors++;
      $display("FAIL rd_busy step %0d: got %b want %b", id, rd_busy_o, e.busy);
    end
    checks++;
    if (iss_ready_o !== e.ready) begin
      errors++;
      $display("FAIL iss_ready step %0d: got %b want %b", id, iss_ready_o, e.ready);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rs wen    wa1 wa0 wd1            wd0            clr   iv ird ra1 ra0 ed1            ed0            eb     er
    tbl[0]  = mk(0, 2'b11, 2,  1,  32'h2222_2222, 32'h1111_1111, 2'b00, 0, 0,  2,  1,  32'h2222_2222, 32'h1111_1111, 2'b00, 1);
    tbl[1]  = mk(0, 2'b00, 0,  0,  32'h0,         32'h0,         2'b00, 1, 4,  2,  1,  32'h2222_2222, 32'h1111_1111, 2'b00, 1);
    tbl[2]  = mk(1, 2'b01, 0,  3,  32'h0,         32'h33,        2'b00, 0, 0,  4,  1,  32'h0,         32'h1111_1111, 2'b10, 1);
    tbl[3]  = mk(0, 2'b00, 0,  0,  32'h0,         32'h0,         2'b00, 0, 4,  3,  1,  32'h0,         32'h0,         2'b00, 1);
    tbl[4]  = mk(0, 2'b11, 5,  5,  32'h1234_5678, 32'hDEAD_BEEF, 2'b00, 0, 0,  5,  5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 1);
    tbl[5]  = mk(0, 2'b00, 0,  0,  32'h0,         32'h0,         2'b00, 0, 0,  2,  5,  32'h0,         32'hDEAD_BEEF, 2'b00, 1);
    tbl[6]  = mk(0, 2'b11, 0,  0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 1, 0,  0,  0,  32'h0,         32'h0,         2'b00, 1);
    tbl[7]  = mk(0, 2'b00, 0,  0,  32'h0,         32'h0,         2'b00, 1, 0,  5,  0,  32'hDEAD_BEEF, 32'h0,         2'b00, 1);
    tbl[8]  = mk(0, 2'b00, 0,  0,  32'h0,         32'h0,         2'b00, 1, 7,  5,  7,  32'hDEAD_BEEF, 32'h0,         2'b00, 1);
    tbl[9]  = mk(0, 2'b00, 0,  0,  32'h0,         32'h0,         2'b00, 0, 7,  7,  7,  32'h0,         32'h0,         2'b11, 0);
    tbl[10] = mk(0, 2'b10, 7,  0,  32'h42,        32'h0,         2'b10, 0, 7,  6,  7,  32'h0,         32'h42,        2'b00, 1);
    tbl[11] = mk(0, 2'b00, 0,  0,  32'h0,         32'h0,         2'b00, 0, 7,  7,  7,  32'h42,        32'h42,        2'b00, 1);
    tbl[12] = mk(0, 2'b00, 0,  0,  32'h0,         32'h0,         2'b00, 1, 9,  9,  7,  32'h0,         32'h42,        2'b00, 1);
    tbl[13] = mk(0, 2'b01, 0,  9,  32'h0,         32'h99,        2'b01, 1, 9,  9,  9,  32'h99,        32'h99,        2'b00, 1);
    tbl[14] = mk(0, 2'b00, 0,  0,  32'h0,         32'h0,         2'b00, 0, 9,  9,  9,  32'h99,        32'h99,        2'b11, 0);
    tbl[15] = mk(0, 2'b11, 9,  10, 32'h9A,        32'hA0,        2'b10, 0, 9,  9,  10, 32'h9A,        32'hA0,        2'b00, 1);
    tbl[16] = mk(0, 2'b00, 0,  0,  32'h0,         32'h0,         2'b00, 1, 11, 9,  10, 32'h9A,        32'hA0,        2'b00, 1);
    tbl[17] = mk(0, 2'b10, 11, 11, 32'hBB,        32'h0,         2'b01, 0, 11, 11, 11, 32'hBB,        32'hBB,        2'b11, 0);
    tbl[18] = mk(0, 2'b00, 0,  0,  32'h0,         32'h0,         2'b00, 0, 11, 11, 11, 32'hBB,        32'hBB,        2'b11, 0);
    tbl[19] = mk(0, 2'b01, 0,  3,  32'h0,         32'h3333,      2'b00, 1, 3,  11, 3,  32'hBB,        32'h3333,      2'b10, 1);
    tbl[20] = mk(1, 2'b01, 0,  3,  32'h0,         32'h77,        2'b01, 0, 3,  11, 3,  32'hBB,        32'h77,        2'b10, 1);
    tbl[21] = mk(0, 2'b00, 0,  0,  32'h0,         32'h0,         2'b00, 0, 11, 11, 3,  32'h0,         32'h0,         2'b00, 1);

    rst         = 1'b1;
    wr_en_i     = '0;
    wr_addr_i   = '0;
    wr_data_i   = '0;
    wr_clr_i    = '0;
    iss_valid_i = 1'b0;
    iss_rd_i    = '0;
    rd_addr_i   = '0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      step(tbl[i], i);
    end

    // Fill every register two at a time (distinct addresses on both ports),
    // checking the bypassed values during the write cycle.
    for (int r = 1; r < 32; r += 2) begin
      logic [1:0]  en;
      logic [31:0] d1;
      en = (r < 31) ? 2'b11 : 2'b01;
      d1 = (r < 31) ? pat(r + 1) : 32'h0;
      step(mk(0, en, 5'(r + 1), 5'(r), pat(r + 1), pat(r), 2'b00, 0, 0,
              5'((r < 31) ? r + 1 : 0), 5'(r), d1, pat(r), 2'b00, 1), 100 + r);
    end

    // Read everything back from storage on both ports.
    for (int r = 1; r < 32; r++) begin
      step(mk(0, 2'b00, 0, 0, 32'h0, 32'h0, 2'b00, 0, 0,
              5'(32 - r), 5'(r), pat(32 - r), pat(r), 2'b00, 1), 200 + r);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
